// File: rtl/serial_addsub_unit_pkg.sv
// Shared encodings for the digit-serial add/subtract unit.
// Mode values and the FSM state type used by the top level.
package serial_addsub_unit_pkg;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Extension bit of the result: carry for add, borrow (inverted carry) for subtract.
  function automatic logic ext_flag(input logic mode, input logic cout);
    return (mode == ModeAdd) ? cout : ~cout;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder slice.
// Also reports the carry into its top bit so the caller can derive signed overflow.
module addsub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement add/subtract unit, LSB digit first, DIGIT bits per clock.
// Valid/ready on both sides; result and flags are registered and held until consumed.
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_res,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH:0]   out_res_q;
  logic             out_cout_q;
  logic             out_ovf_q;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   last_digit;

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the MSB end; after NDIG shifts the sum is aligned.
  assign res_cat    = {dig_sum, res_q};
  assign res_shift  = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= ModeAdd;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b ^ {WIDTH{in_mode == ModeSub}};
            carry_q <= in_mode;
            mode_q  <= in_mode;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_shift;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_digit) begin
            out_res_q   <= {ext_flag(mode_q, dig_cout), res_shift};
            out_cout_q  <= dig_cout;
            out_ovf_q   <= dig_cmsb ^ dig_cout;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: a 16/4 instance and an 8/8 instance.
module tb_serial_addsub_unit;
  import serial_addsub_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] in_a, in_b;
  logic [16:0] out_res;

  logic        v8_in_valid, v8_in_ready, v8_in_mode, v8_out_valid, v8_out_ready;
  logic        v8_out_cout, v8_out_ovf;
  logic [7:0]  v8_in_a, v8_in_b;
  logic [8:0]  v8_out_res;

  int n_total = 0;
  int n_pass  = 0;

  serial_addsub_unit #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  serial_addsub_unit #(
    .WIDTH (8),
    .DIGIT (8)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8_in_valid),
    .in_ready  (v8_in_ready),
    .in_mode   (v8_in_mode),
    .in_a      (v8_in_a),
    .in_b      (v8_in_b),
    .out_valid (v8_out_valid),
    .out_ready (v8_out_ready),
    .out_res   (v8_out_res),
    .out_cout  (v8_out_cout),
    .out_ovf   (v8_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start16(input logic mode, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait16(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release16();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_consume", 32'(out_valid), 32'd0);
  endtask

  task automatic op16(input string tag, input logic mode, input logic [15:0] a,
                      input logic [15:0] b, input logic [16:0] exp_res,
                      input logic exp_cout, input logic exp_ovf);
    int cyc;
    start16(mode, a, b);
    wait16(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    chk({tag, "_res"}, 32'(out_res), 32'(exp_res));
    chk({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    release16();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acc, first, second, nres, bad;
    logic seen;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_mode      = ModeAdd;
    in_a         = '0;
    in_b         = '0;
    out_ready    = 1'b0;
    v8_in_valid  = 1'b0;
    v8_in_mode   = ModeAdd;
    v8_in_a      = '0;
    v8_in_b      = '0;
    v8_out_ready = 1'b0;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_v8_out_valid", 32'(v8_out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    op16("sub_1234_0234", ModeSub, 16'h1234, 16'h0234, 17'h01000, 1'b1, 1'b0);
    op16("sub_0_1",       ModeSub, 16'h0000, 16'h0001, 17'h1FFFF, 1'b0, 1'b0);
    op16("add_ffff_1",    ModeAdd, 16'hFFFF, 16'h0001, 17'h10000, 1'b1, 1'b0);
    op16("add_7fff_1",    ModeAdd, 16'h7FFF, 16'h0001, 17'h08000, 1'b0, 1'b1);
    op16("sub_equal",     ModeSub, 16'hA5A5, 16'hA5A5, 17'h00000, 1'b1, 1'b0);
    op16("sub_b_zero",    ModeSub, 16'h4321, 16'h0000, 17'h04321, 1'b1, 1'b0);
    op16("add_8000_8000", ModeAdd, 16'h8000, 16'h8000, 17'h10000, 1'b1, 1'b1);

    // Held result while the consumer stalls; in_valid pulses must be ignored.
    start16(ModeSub, 16'h8000, 16'h0001);
    wait16(cyc);
    chk("hold_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = ModeAdd;
      in_a     = 16'hFFFF;
      in_b     = 16'hFFFF;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_res", 32'(out_res), 32'h07FFF);
    end
    in_valid = 1'b0;
    chk("hold_cout", 32'(out_cout), 32'd1);
    chk("hold_ovf", 32'(out_ovf), 32'd1);
    release16();

    // Reset in the middle of RUN.
    start16(ModeAdd, 16'h1111, 16'h2222);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstrun_out_valid", 32'(out_valid), 32'd0);
    chk("rstrun_out_res", 32'(out_res), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("rstrun_no_result", 32'(seen), 32'd0);
    chk("rstrun_in_ready", 32'(in_ready), 32'd1);
    op16("sub_5_3", ModeSub, 16'h0005, 16'h0003, 17'h00002, 1'b1, 1'b0);

    // Reset while a result is waiting in DONE.
    start16(ModeAdd, 16'hFFFF, 16'h0001);
    wait16(cyc);
    chk("rstdone_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstdone_out_valid", 32'(out_valid), 32'd0);
    chk("rstdone_out_res", 32'(out_res), 32'd0);
    chk("rstdone_out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstdone_in_ready", 32'(in_ready), 32'd1);

    // 8-bit instance, single digit: one RUN cycle.
    @(negedge clk);
    v8_in_valid = 1'b1;
    v8_in_mode  = ModeSub;
    v8_in_a     = 8'h03;
    v8_in_b     = 8'h05;
    @(negedge clk);
    v8_in_valid = 1'b0;
    cyc = 0;
    while (v8_out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("w8_latency", 32'(cyc), 32'd1);
    chk("w8_res", 32'(v8_out_res), 32'h1FE);
    chk("w8_cout", 32'(v8_out_cout), 32'd0);
    chk("w8_ovf", 32'(v8_out_ovf), 32'd0);
    @(negedge clk);
    v8_out_ready = 1'b1;
    @(negedge clk);
    chk("w8_consumed", 32'(v8_out_valid), 32'd0);

    // Back-to-back with out_ready held high.
    v8_in_valid = 1'b1;
    acc = 0; first = -1; second = -1; nres = 0; bad = 0;
    for (int e = 0; e < 9; e++) begin
      if (v8_in_ready === 1'b1) begin
        acc++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      if (v8_out_valid === 1'b1) begin
        nres++;
        if (v8_out_res !== 9'h1FE) bad++;
      end
      @(negedge clk);
    end
    v8_in_valid  = 1'b0;
    v8_out_ready = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_spacing", 32'(second - first), 32'd3);
    chk("b2b_results", 32'(nres), 32'd3);
    chk("b2b_bad_results", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
